// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: drives the instruction-memory PC and buffers {PC, Instr} pairs
// in a circular queue for decode; handles redirect, halt and PC wrap-around.
module instr_fetch_unit #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     QDEPTH      = 4,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    F_PC,
    input  logic [INSTR_WIDTH-1:0] Instr,
    input  logic                   br_valid,
    input  logic [PC_WIDTH-1:0]    br_target,
    output logic                   D_valid,
    input  logic                   D_ready,
    output logic [INSTR_WIDTH-1:0] D_Instr,
    output logic [PC_WIDTH-1:0]    D_PC,
    output logic                   halted
);
    localparam int AW = $clog2(QDEPTH);
    logic [PC_WIDTH-1:0]    pc_q [QDEPTH];
    logic [INSTR_WIDTH-1:0] in_q [QDEPTH];
    logic [AW-1:0]          rd, wr;
    logic [AW:0]            count;
    logic                   deq, can_fetch, is_halt;
    assign D_valid   = count != '0;
    assign deq       = D_valid & D_ready;
    // count top bit set means full, since QDEPTH is a power of two
    assign can_fetch = !halted & (!count[AW] | deq);
    assign is_halt   = Instr == HALT_INSTR;
    assign D_Instr   = in_q[rd];
    assign D_PC      = pc_q[rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_PC   <= RESET_PC;
            halted <= 1'b0;
            rd     <= '0;
            wr     <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i] <= '0;
                in_q[i] <= '0;
            end
        end else if (br_valid) begin
            F_PC   <= br_target;
            halted <= 1'b0;
            rd     <= '0;
            wr     <= '0;
            count  <= '0;
        end else begin
            if (deq) rd <= rd + 1'b1;
            if (can_fetch) begin
                pc_q[wr] <= F_PC;
                in_q[wr] <= Instr;
                wr       <= wr + 1'b1;
                halted   <= is_halt;
                if (!is_halt) F_PC <= F_PC + 1'b1;
            end
            count <= count + {{AW{1'b0}}, can_fetch} - {{AW{1'b0}}, deq};
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: queue-based reference model plus directed and random stimulus.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, br_valid, D_ready, D_valid, halted, halt_en;
    logic [15:0] F_PC, br_target, D_PC;
    logic [31:0] Instr, D_Instr;
    logic [16:0] halt_addr;
    logic [15:0] F_PC2, D_PC2;
    logic [31:0] Instr2, D_Instr2;
    logic        D_valid2, halted2;
    int          checks = 0, errors = 0;

    logic [15:0] qpc [$];
    logic [31:0] qin [$];
    logic [15:0] mpc;
    logic        mh;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [15:0] a, logic [16:0] h, logic en);
        return ({1'b0, a} == h || (en && a[4:0] == 5'h1F)) ? 32'hFFFF_FFFF : 32'h1000_0000 + {16'h0, a};
    endfunction

    assign Instr  = mem_word(F_PC, halt_addr, halt_en);
    assign Instr2 = 32'h1000_0000 + {16'h0, F_PC2};

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .F_PC(F_PC), .Instr(Instr),
        .br_valid(br_valid), .br_target(br_target), .D_valid(D_valid),
        .D_ready(D_ready), .D_Instr(D_Instr), .D_PC(D_PC), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .F_PC(F_PC2), .Instr(Instr2),
        .br_valid(1'b0), .br_target(16'h0000), .D_valid(D_valid2),
        .D_ready(1'b1), .D_Instr(D_Instr2), .D_PC(D_PC2), .halted(halted2)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a plain queue of fetched {PC, word} pairs advanced once per edge
    initial begin
        logic        d, f;
        logic [31:0] w;
        mpc = 16'h0;
        mh  = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || br_valid) begin
                qpc.delete();
                qin.delete();
                mpc = rst_n ? br_target : 16'h0;
                mh  = 1'b0;
            end else begin
                d = qpc.size() != 0 && D_ready;
                f = !mh && (qpc.size() < 4 || d);
                if (d) begin
                    void'(qpc.pop_front());
                    void'(qin.pop_front());
                end
                if (f) begin
                    w = mem_word(mpc, halt_addr, halt_en);
                    qpc.push_back(mpc);
                    qin.push_back(w);
                    if (w == 32'hFFFF_FFFF) mh = 1'b1;
                    else mpc = mpc + 16'h1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("F_PC", {16'h0, F_PC}, {16'h0, mpc});
            chk("halted", {31'h0, halted}, {31'h0, mh});
            chk("D_valid", {31'h0, D_valid}, {31'h0, qpc.size() != 0});
            if (qpc.size() != 0) begin
                chk("D_PC", {16'h0, D_PC}, {16'h0, qpc[0]});
                chk("D_Instr", D_Instr, qin[0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] e;
        rst_n = 1'b0; D_ready = 1'b1; br_valid = 1'b0; br_target = 16'h0;
        halt_addr = 17'h1FFFF; halt_en = 1'b0;
        step(); step();
        chk("rst_D_valid", {31'h0, D_valid}, 32'h0);
        chk("rst_D_PC", {16'h0, D_PC}, 32'h0);
        chk("rst_D_Instr", D_Instr, 32'h0);
        chk("rst_F_PC", {16'h0, F_PC}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_F_PC2", {16'h0, F_PC2}, 32'h0000_FFFE);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_D_valid", {31'h0, D_valid}, 32'h1);
            chk("seq_D_PC", {16'h0, D_PC}, i);
            chk("seq_D_Instr", D_Instr, 32'h1000_0000 + i);
            e = 16'hFFFE + 16'(i);
            chk("wrap_D_PC", {16'h0, D_PC2}, {16'h0, e});
            chk("wrap_D_valid", {31'h0, D_valid2}, 32'h1);
        end
        D_ready = 1'b0;
        do_reset();
        repeat (8) step();
        chk("bp_F_PC", {16'h0, F_PC}, 32'h4);
        chk("bp_D_PC", {16'h0, D_PC}, 32'h0);
        D_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            step();
            chk("bp_drain_D_PC", {16'h0, D_PC}, i);
        end
        D_ready = 1'b0;
        do_reset();
        repeat (3) step();
        br_valid = 1'b1; br_target = 16'h0009;
        step();
        chk("br_D_valid", {31'h0, D_valid}, 32'h0);
        chk("br_F_PC", {16'h0, F_PC}, 32'h9);
        br_valid = 1'b0; D_ready = 1'b1;
        step();
        chk("br_D_PC", {16'h0, D_PC}, 32'h9);
        chk("br_D_Instr", D_Instr, 32'h1000_0009);
        step();
        chk("br_next_D_PC", {16'h0, D_PC}, 32'hA);
        halt_addr = 17'h6;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("halt_seq_D_PC", {16'h0, D_PC}, i);
        end
        chk("halt_set", {31'h0, halted}, 32'h1);
        chk("halt_F_PC", {16'h0, F_PC}, 32'h6);
        chk("halt_word", D_Instr, 32'hFFFF_FFFF);
        step(); step();
        chk("halt_D_valid", {31'h0, D_valid}, 32'h0);
        chk("halt_F_PC_hold", {16'h0, F_PC}, 32'h6);
        br_valid = 1'b1; br_target = 16'h0001;
        step();
        chk("unhalt_halted", {31'h0, halted}, 32'h0);
        chk("unhalt_F_PC", {16'h0, F_PC}, 32'h1);
        br_valid = 1'b0;
        step();
        chk("unhalt_D_PC", {16'h0, D_PC}, 32'h1);
        halt_addr = 17'h1FFFF; D_ready = 1'b0;
        do_reset();
        repeat (6) step();
        chk("full_D_valid", {31'h0, D_valid}, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_D_valid", {31'h0, D_valid}, 32'h0);
        chk("async_F_PC", {16'h0, F_PC}, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("async_idle_D_valid", {31'h0, D_valid}, 32'h0);
        step();
        chk("async_restart_D_PC", {16'h0, D_PC}, 32'h0);
        chk("async_restart_D_valid", {31'h0, D_valid}, 32'h1);
        halt_en = 1'b1;
        repeat (2000) begin
            step();
            D_ready   = $urandom_range(0, 3) != 0;
            br_valid  = $urandom_range(0, 15) == 0;
            br_target = 16'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
